spi_ram_slave_p: RTL and testbench

Parametrised SPI slave with an integrated single-port synchronous RAM. Frame width, address width and data width are parameters, replacing the fixed 10-bit-frame / 8-bit-data / 256-deep pairing.
- Serial frames (command + payload) set write/read addresses, write data, or trigger a read-back serialised on MISO.
- Adds a frame-abort error flag and optional address auto-increment for burst transfers.
- Sits at the chip boundary; clk is the SPI clock domain.

---
 rtl/spi_ram_slave_p.sv | 135 +++++++++++++
 tb/tb_spi_ram_slave_p.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_slave_p.sv
// SPI slave with an internal single-port RAM: serial frames set addresses, write data or
// stream a word back on MISO. Define SPI_RAM_AUTO_INC_EN for address post-increment on bursts.
module spi_ram_slave_p #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic MOSI,
   input  logic SS_n,
   output logic MISO,
   output logic frame_err
);

   localparam int P     = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int F     = P + 2;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = $clog2(F + 1);

   typedef enum logic [1:0] {StIdle, StRecv, StExec, StReadout} state_e;

   state_e                r_state, w_next_state;
   logic [F-1:0]          r_sr;
   logic [CW-1:0]         r_cnt;
   logic [ADDR_WIDTH-1:0] r_wr_addr, r_rd_addr;
   logic [DATA_WIDTH-1:0] r_tx;
   logic                  r_miso, r_err;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [1:0]   w_cmd;
   logic [P-1:0] w_payload;
   logic         w_last_bit, w_rd_done;
   logic         w_abort, w_shift_in, w_shift_out, w_exec, w_mem_we;

   assign w_cmd      = r_sr[F-1:F-2];
   assign w_payload  = r_sr[P-1:0];
   assign w_last_bit = (r_cnt == CW'(F - 1));
   assign w_rd_done  = (r_cnt == CW'(DATA_WIDTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         StIdle:    if (!SS_n) w_next_state = StRecv;
         StRecv: begin
            if (SS_n)            w_next_state = StIdle;
            else if (w_last_bit) w_next_state = StExec;
         end
         StExec:    w_next_state = (w_cmd == 2'b11) ? StReadout : StIdle;
         StReadout: if (w_rd_done || SS_n) w_next_state = StIdle;
         default:   w_next_state = StIdle;
      endcase
   end

   // The edge that retires the last readout bit completes the frame even if SS_n already rose.
   always_comb begin
      w_abort     = 1'b0;
      w_shift_in  = 1'b0;
      w_shift_out = 1'b0;
      w_exec      = 1'b0;
      w_mem_we    = 1'b0;
      case (r_state)
         StRecv: begin
            w_abort    = SS_n;
            w_shift_in = !SS_n;
         end
         StExec: begin
            w_exec   = 1'b1;
            w_mem_we = (w_cmd == 2'b01);
         end
         StReadout: begin
            w_abort     = SS_n && !w_rd_done;
            w_shift_out = !SS_n && !w_rd_done;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr      <= '0;
         r_cnt     <= '0;
         r_wr_addr <= '0;
         r_rd_addr <= '0;
         r_tx      <= '0;
         r_miso    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_err <= w_abort;
         if (w_shift_in) begin
            r_sr  <= {r_sr[F-2:0], MOSI};
            r_cnt <= w_last_bit ? '0 : r_cnt + 1'b1;
         end else if (w_shift_out) begin
            r_miso <= r_tx[DATA_WIDTH-1];
            r_tx   <= r_tx << 1;
            r_cnt  <= r_cnt + 1'b1;
         end else begin
            r_miso <= 1'b0;
            r_cnt  <= '0;
            r_sr   <= '0;
         end
         if (w_exec) begin
            case (w_cmd)
               2'b00: r_wr_addr <= w_payload[ADDR_WIDTH-1:0];
               2'b01: begin
`ifdef SPI_RAM_AUTO_INC_EN
                  r_wr_addr <= r_wr_addr + 1'b1;
`else
                  r_wr_addr <= r_wr_addr;
`endif
               end
               2'b10: r_rd_addr <= w_payload[ADDR_WIDTH-1:0];
               default: begin
                  r_tx <= r_mem[r_rd_addr];
`ifdef SPI_RAM_AUTO_INC_EN
                  r_rd_addr <= r_rd_addr + 1'b1;
`endif
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[r_wr_addr] <= w_payload[DATA_WIDTH-1:0];
   end

   assign MISO      = r_miso;
   assign frame_err = r_err;

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Directed bench for spi_ram_slave_p: a default 8/8 instance and a 10/16 instance.
module tb_spi_ram_slave_p;

   logic clk, rst;
   logic ss_n_a, mosi_a, miso_a, err_a;
   logic ss_n_b, mosi_b, miso_b, err_b;
   int   checks, failures;
   int   err_cnt_a, err_cnt_b, exp_err_a;
   logic [15:0] rd;

   spi_ram_slave_p u_dut_a (
      .clk(clk), .rst(rst), .MOSI(mosi_a), .SS_n(ss_n_a), .MISO(miso_a), .frame_err(err_a)
   );

   spi_ram_slave_p #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) u_dut_b (
      .clk(clk), .rst(rst), .MOSI(mosi_b), .SS_n(ss_n_b), .MISO(miso_b), .frame_err(err_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (err_a) err_cnt_a++;
      if (err_b) err_cnt_b++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic ss, input logic mo);
      if (sel) begin
         ss_n_b = ss;
         mosi_b = mo;
      end else begin
         ss_n_a = ss;
         mosi_a = mo;
      end
   endtask

   function automatic logic miso_of(input bit sel);
      return sel ? miso_b : miso_a;
   endfunction

   function automatic logic err_of(input bit sel);
      return sel ? err_b : err_a;
   endfunction

   // Drives SS_n low, then cmd/payload MSB first; leaves the DUT just after the last bit edge.
   task automatic send_bits(input bit sel, input logic [1:0] cmd, input logic [15:0] pay,
                            input int nbits);
      int f;
      logic [17:0] fr;
      f = sel ? 18 : 10;
      fr = '0;
      fr[f-1] = cmd[1];
      fr[f-2] = cmd[0];
      for (int i = 0; i < f - 2; i++) fr[i] = pay[i];
      drive(sel, 1'b0, 1'b0);
      tick();
      for (int i = f - 1; i >= f - nbits; i--) begin
         drive(sel, 1'b0, fr[i]);
         tick();
      end
   endtask

   task automatic frame(input bit sel, input logic [1:0] cmd, input logic [15:0] pay,
                        output logic [15:0] data);
      int dw;
      dw = sel ? 16 : 8;
      data = '0;
      send_bits(sel, cmd, pay, sel ? 18 : 10);
      if (cmd != 2'b11) begin
         drive(sel, 1'b1, 1'b0);
         tick();
      end else begin
         drive(sel, 1'b0, 1'b0);
         tick();
         check("miso_before_readout", 32'(miso_of(sel)), 32'd0);
         for (int i = dw - 1; i >= 0; i--) begin
            tick();
            data[i] = miso_of(sel);
         end
         drive(sel, 1'b1, 1'b0);
         tick();
         check("miso_after_readout", 32'(miso_of(sel)), 32'd0);
      end
   endtask

   task automatic abort_recv(input bit sel, input logic [1:0] cmd, input logic [15:0] pay,
                             input int nbits);
      send_bits(sel, cmd, pay, nbits);
      drive(sel, 1'b1, 1'b0);
      tick();
      check("abort_err_pulse", 32'(err_of(sel)), 32'd1);
      check("abort_miso", 32'(miso_of(sel)), 32'd0);
      tick();
      check("abort_err_clear", 32'(err_of(sel)), 32'd0);
   endtask

   initial begin
      logic [2:0] part;
      checks = 0;
      failures = 0;
      err_cnt_a = 0;
      err_cnt_b = 0;
      exp_err_a = 0;
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      repeat (3) tick();
      check("reset_miso_a", 32'(miso_a), 32'd0);
      check("reset_err_a", 32'(err_a), 32'd0);
      check("reset_miso_b", 32'(miso_b), 32'd0);
      rst = 1'b0;
      tick();

      // Basic write/read of 0xA5 at 0x12
      frame(1'b0, 2'b00, 16'h12, rd);
      frame(1'b0, 2'b01, 16'hA5, rd);
      frame(1'b0, 2'b10, 16'h12, rd);
      frame(1'b0, 2'b11, 16'h00, rd);
      check("basic_read_a5", 32'(rd), 32'hA5);
      check("basic_no_err", err_cnt_a, 0);

      // Abort after 5 bits of a write leaves RAM and wr_addr untouched
      frame(1'b0, 2'b00, 16'h12, rd);
      abort_recv(1'b0, 2'b01, 16'h3C, 5);
      exp_err_a++;
      frame(1'b0, 2'b10, 16'h12, rd);
      frame(1'b0, 2'b11, 16'h00, rd);
      check("abort_ram_kept", 32'(rd), 32'hA5);
      frame(1'b0, 2'b01, 16'h3C, rd);
      frame(1'b0, 2'b10, 16'h12, rd);
      frame(1'b0, 2'b11, 16'h00, rd);
      check("after_abort_write", 32'(rd), 32'h3C);

      // Abort during readout of 0x3C after three bits (0,0,1)
      frame(1'b0, 2'b10, 16'h12, rd);
      send_bits(1'b0, 2'b11, 16'h00, 10);
      tick();
      for (int i = 2; i >= 0; i--) begin
         tick();
         part[i] = miso_a;
      end
      check("readout_partial_bits", 32'(part), 32'b001);
      drive(1'b0, 1'b1, 1'b0);
      tick();
      check("readout_abort_err", 32'(err_a), 32'd1);
      check("readout_abort_miso", 32'(miso_a), 32'd0);
      tick();
      check("readout_abort_err_clear", 32'(err_a), 32'd0);
      exp_err_a++;
      frame(1'b0, 2'b10, 16'h12, rd);
      frame(1'b0, 2'b11, 16'h00, rd);
      check("readout_after_abort", 32'(rd), 32'h3C);

      // rd_addr is 0 after reset
      frame(1'b0, 2'b00, 16'h00, rd);
      frame(1'b0, 2'b01, 16'h5A, rd);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      frame(1'b0, 2'b11, 16'h00, rd);
      check("reset_rd_addr_zero", 32'(rd), 32'h5A);

      // Reset at bit 7 of a write frame
      frame(1'b0, 2'b00, 16'h20, rd);
      frame(1'b0, 2'b01, 16'h77, rd);
      frame(1'b0, 2'b00, 16'h20, rd);
      send_bits(1'b0, 2'b01, 16'h99, 7);
      rst = 1'b1;
      #2;
      check("midreset_miso", 32'(miso_a), 32'd0);
      check("midreset_err", 32'(err_a), 32'd0);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b1, 1'b0);
      tick();
      frame(1'b0, 2'b01, 16'h44, rd);
      frame(1'b0, 2'b11, 16'h00, rd);
      check("midreset_wr_addr_zero", 32'(rd), 32'h44);
      frame(1'b0, 2'b10, 16'h20, rd);
      frame(1'b0, 2'b11, 16'h00, rd);
      check("midreset_ram_kept", 32'(rd), 32'h77);

`ifdef SPI_RAM_AUTO_INC_EN
      frame(1'b0, 2'b00, 16'hFF, rd);
      frame(1'b0, 2'b01, 16'h11, rd);
      frame(1'b0, 2'b01, 16'h22, rd);
      frame(1'b0, 2'b10, 16'hFF, rd);
      frame(1'b0, 2'b11, 16'h00, rd);
      check("autoinc_read_ff", 32'(rd), 32'h11);
      frame(1'b0, 2'b11, 16'h00, rd);
      check("autoinc_read_wrap", 32'(rd), 32'h22);
`else
      frame(1'b0, 2'b00, 16'h30, rd);
      frame(1'b0, 2'b01, 16'h11, rd);
      frame(1'b0, 2'b01, 16'h22, rd);
      frame(1'b0, 2'b10, 16'h30, rd);
      frame(1'b0, 2'b11, 16'h00, rd);
      check("noinc_overwrite", 32'(rd), 32'h22);
      frame(1'b0, 2'b11, 16'h00, rd);
      check("noinc_reread", 32'(rd), 32'h22);
`endif
      check("err_count_a", err_cnt_a, exp_err_a);

      // Wide instance: F=18, 16-bit data, readout starts at edge k+20
      frame(1'b1, 2'b00, 16'h03FF, rd);
      frame(1'b1, 2'b01, 16'hBEEF, rd);
      frame(1'b1, 2'b10, 16'h03FF, rd);
      frame(1'b1, 2'b11, 16'h0000, rd);
      check("wide_read_beef", 32'(rd), 32'hBEEF);
      // Payload bits above ADDR_WIDTH are ignored: 0x7C05 selects address 0x005
      frame(1'b1, 2'b00, 16'h7C05, rd);
      frame(1'b1, 2'b01, 16'h1234, rd);
      frame(1'b1, 2'b10, 16'h0005, rd);
      frame(1'b1, 2'b11, 16'h0000, rd);
      check("wide_addr_trunc", 32'(rd), 32'h1234);
      check("err_count_b", err_cnt_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
